tiny_enc: RTL and testbench
===========================

// Module: tiny_enc
// PURPOSE
// - 32-bit TEA block cipher core with an APB register port. One RTL file with a DECRYPT parameter.
// - tinyenc = tiny_enc #(.DECRYPT(0)); tinydec = thin wrapper tiny_dec = tiny_enc #(.DECRYPT(1)).
// - Self-timed: any change of wdata launches a computation; ack=1 marks rdata valid for the current wdata.
// - Encrypt and decrypt instances chain directly: dec.wdata = enc.rdata, shared req.
// PARAMETERS
// - KEY     64'h816fc52b09e74da3  reset key; k0=KEY[15:0], k1=[31:16], k2=[47:32], k3=[63:48]
// - DELTA   16'h0123              reset round constant
// - SHL     4                     left shift in round function
// - SHR     5                     right shift in round function
// - DECRYPT 0                     0 = encrypt, 1 = decrypt
// PORTS
// - pclk     in   1   single clock; all state on rising edge
// - prstb    in   1   reset, asynchronous, active-low
// - clk      in   1   unused; kept for pin compatibility, no logic attached
// - wdata    in   32  operand; v0=wdata[15:0], v1=wdata[31:16]
// - req      in   1   request level; no start function (see BEHAVIOUR)
// - rdata    out  32  result {v1,v0}
// - ack      out  1   1 = idle and rdata valid
// - psel, penable, pwrite  in 1 each   APB control
// - paddr    in   32  APB address
// - pwdata   in   32  APB write data
// BEHAVIOUR
// - Single clock pclk; reset prstb asynchronous, active-low. clk is ignored.
// - Reset values:
//   - ack=1, rdata=0, operand reg op=0
//   - key=KEY, delta=DELTA, ctrl=0 (disabled)
// - APB write strobe: psel&penable&pwrite; no wait states; no read data; unmapped addresses ignored.
// - Register map:
//   - 0x0 key[31:0]
//   - 0x4 key[63:32]
//   - 0x8 delta[15:0]
//   - 0xC ctrl: [3]=EN, [2:0]=RC, N = RC+1 cycles (1..8)
// - States:
//   - IDLE (ack=1)
//   - BUSY (ack=0, counter cnt 0..N-1)
// - Start, in IDLE with EN=1 and wdata!=op, at that edge:
//   - op<=wdata, v<=wdata, cnt<=0, ack<=0
//   - sum<=0 (enc) or sum<=delta*N mod 2^16 (dec)
// - req is never a start condition. req=1 with wdata==op leaves ack=1 and rdata unchanged.
// - One TEA cycle per pclk, all arithmetic mod 2^16, F(x,s,ka,kb) = ((x<<SHL)+ka) ^ (x+s) ^ ((x>>SHR)+kb).
//   - enc:
//     - s=sum+delta; v0+=F(v1,s,k0,k1); v1+=F(v0new,s,k2,k3); sum<=s
//   - dec:
//     - v1-=F(v0,sum,k2,k3); v0-=F(v1new,sum,k0,k1); sum<=sum-delta
// - Completion on the N-th BUSY edge: rdata<={v1,v0}, ack<=1.
//   - Latency from wdata change to ack rise = N+1 pclk edges.
// - wdata differs from op while BUSY: restart at that edge with the new operand (same actions as start); ack stays 0.
// - EN cleared while BUSY: abort to IDLE at that edge, ack<=1, rdata unchanged.
// - EN=0 in IDLE: no starts; ack=1.
// - key/delta/ctrl writes take effect at the next start.
//   - The running computation keeps the values captured at start: key, delta, N.
// - prstb low mid-operation: immediate return to reset values.
// - Chained enc->dec: dec sees the cipher change one edge after enc ack rises.
//   - dec ack rises N+1 edges later with plain == enc operand.
// STRUCTURE
// - Package tea_pkg:
//   - ADDR_KEY_LO=0x0, ADDR_KEY_HI=0x4, ADDR_DELTA=0x8, ADDR_CTRL=0xC
//   - CTRL_EN_BIT=3
//   - function tea_f(x,s,ka,kb,shl,shr)
//   - state typedef {IDLE,BUSY}
// - One sub-module tea_round: combinational single-cycle enc/dec step selected by DECRYPT.
// - APB register file and FSM stay inline.
// TESTING
// - Reset -> ack=1, rdata=0; with EN=0 a wdata change leaves ack=1.
// - APB writes:
//   - key=0, delta=0, ctrl=0x8 (N=1)
//   - enc wdata=0x0001_0000 -> ack low 1 edge later, high 2 edges after the change, rdata=0x0102_0011
// - Defaults, ctrl=0x8|RC for RC=0..7:
//   - random printable 4-byte text through the enc->dec chain, 33 words each -> dec rdata == text every time
// - Change wdata mid-BUSY -> restart; final rdata matches the new operand; exactly one ack rise.
// - Clear EN (ctrl=0x0..0x7) mid-BUSY -> ack=1 next edge, rdata unchanged.
// - Assert prstb low mid-BUSY -> ack=1, rdata=0 immediately; ctrl=0; key/delta back to parameters.

Source files
------------

// File: rtl/tea_pkg.sv
// Shared definitions for the 16-bit-half TEA cipher core: register map,
// control bit positions, FSM state type and the TEA round function.
package tea_pkg;

    localparam logic [31:0] ADDR_KEY_LO = 32'h0000_0000;
    localparam logic [31:0] ADDR_KEY_HI = 32'h0000_0004;
    localparam logic [31:0] ADDR_DELTA  = 32'h0000_0008;
    localparam logic [31:0] ADDR_CTRL   = 32'h0000_000C;

    localparam int CTRL_EN_BIT = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic logic [15:0] tea_f(
        input logic [15:0] x,
        input logic [15:0] s,
        input logic [15:0] ka,
        input logic [15:0] kb,
        input int unsigned shl,
        input int unsigned shr
    );
        return ((x << shl) + ka) ^ (x + s) ^ ((x >> shr) + kb);
    endfunction

endpackage

// File: rtl/tea_round.sv
// One combinational TEA cycle on a {v1,v0} block; DECRYPT selects the
// inverse step, which walks sum downward from delta*N.
module tea_round
    import tea_pkg::*;
#(
    parameter bit          DECRYPT = 1'b0,
    parameter int unsigned SHL     = 4,
    parameter int unsigned SHR     = 5
) (
    input  logic [31:0] v_i,
    input  logic [15:0] sum_i,
    input  logic [15:0] delta_i,
    input  logic [63:0] key_i,
    output logic [31:0] v_o,
    output logic [15:0] sum_o
);

    logic [15:0] k0, k1, k2, k3;
    logic [15:0] v0, v1;
    logic [15:0] v0_n, v1_n;
    logic [15:0] s_enc;

    assign k0 = key_i[15:0];
    assign k1 = key_i[31:16];
    assign k2 = key_i[47:32];
    assign k3 = key_i[63:48];
    assign v0 = v_i[15:0];
    assign v1 = v_i[31:16];

    always_comb begin
        s_enc = sum_i + delta_i;
        v0_n  = v0;
        v1_n  = v1;
        sum_o = sum_i;
        // Decrypt undoes the halves in reverse order with the pre-decrement sum
        if (DECRYPT) begin
            v1_n  = v1 - tea_f(v0, sum_i, k2, k3, SHL, SHR);
            v0_n  = v0 - tea_f(v1_n, sum_i, k0, k1, SHL, SHR);
            sum_o = sum_i - delta_i;
        end else begin
            v0_n  = v0 + tea_f(v1, s_enc, k0, k1, SHL, SHR);
            v1_n  = v1 + tea_f(v0_n, s_enc, k2, k3, SHL, SHR);
            sum_o = s_enc;
        end
    end

    assign v_o = {v1_n, v0_n};

endmodule

// File: rtl/tiny_dec.sv
// Decrypting flavour of the TEA core; identical pins and register map.
module tiny_dec #(
    parameter logic [63:0] KEY   = 64'h816fc52b09e74da3,
    parameter logic [15:0] DELTA = 16'h0123,
    parameter int unsigned SHL   = 4,
    parameter int unsigned SHR   = 5
) (
    input  logic        pclk,
    input  logic        prstb,
    input  logic        clk,
    input  logic [31:0] wdata,
    input  logic        req,
    output logic [31:0] rdata,
    output logic        ack,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata
);

    tiny_enc #(
        .KEY    (KEY),
        .DELTA  (DELTA),
        .SHL    (SHL),
        .SHR    (SHR),
        .DECRYPT(1'b1)
    ) u_core (
        .pclk   (pclk),
        .prstb  (prstb),
        .clk    (clk),
        .wdata  (wdata),
        .req    (req),
        .rdata  (rdata),
        .ack    (ack),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata)
    );

endmodule

// File: rtl/tiny_enc.sv
// Self-timed TEA core with APB-programmed key/delta/ctrl: a new operand on
// wdata starts N round cycles, ack marks rdata valid for the current operand.
module tiny_enc
    import tea_pkg::*;
#(
    parameter logic [63:0] KEY     = 64'h816fc52b09e74da3,
    parameter logic [15:0] DELTA   = 16'h0123,
    parameter int unsigned SHL     = 4,
    parameter int unsigned SHR     = 5,
    parameter bit          DECRYPT = 1'b0
) (
    input  logic        pclk,
    input  logic        prstb,
    input  logic        clk,
    input  logic [31:0] wdata,
    input  logic        req,
    output logic [31:0] rdata,
    output logic        ack,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata
);

    logic [63:0] key_q;
    logic [15:0] delta_q;
    logic [3:0]  ctrl_q;

    state_e      state_q, state_d;
    logic [31:0] op_q, op_d;
    logic [31:0] v_q, v_d;
    logic [15:0] sum_q, sum_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [63:0] key_run_q, key_run_d;
    logic [15:0] delta_run_q, delta_run_d;
    logic [2:0]  rc_run_q, rc_run_d;

    logic        wr_en, en, load, step, done;
    logic [2:0]  rc;
    logic [15:0] n16, sum_init;
    logic [31:0] v_nxt;
    logic [15:0] sum_nxt;
    logic        unused_pins;

    // clk and req have no function; they only exist for pin compatibility
    assign unused_pins = clk ^ req;

    assign wr_en = psel & penable & pwrite;

    always_ff @(posedge pclk or negedge prstb) begin
        if (!prstb) begin
            key_q   <= KEY;
            delta_q <= DELTA;
            ctrl_q  <= 4'h0;
        end else if (wr_en) begin
            case (paddr)
                ADDR_KEY_LO: key_q[31:0]  <= pwdata;
                ADDR_KEY_HI: key_q[63:32] <= pwdata;
                ADDR_DELTA:  delta_q      <= pwdata[15:0];
                ADDR_CTRL:   ctrl_q       <= pwdata[3:0];
                default:     ;
            endcase
        end
    end

    assign en       = ctrl_q[CTRL_EN_BIT];
    assign rc       = ctrl_q[2:0];
    assign n16      = {13'd0, rc} + 16'd1;
    assign sum_init = DECRYPT ? 16'(delta_q * n16) : 16'd0;

    // A differing operand (re)starts in either state; EN gates everything
    assign load = en && (wdata != op_q);
    assign step = (state_q == BUSY) && en && !load;
    assign done = step && (cnt_q == rc_run_q);

    tea_round #(
        .DECRYPT(DECRYPT),
        .SHL    (SHL),
        .SHR    (SHR)
    ) u_round (
        .v_i    (v_q),
        .sum_i  (sum_q),
        .delta_i(delta_run_q),
        .key_i  (key_run_q),
        .v_o    (v_nxt),
        .sum_o  (sum_nxt)
    );

    always_ff @(posedge pclk or negedge prstb) begin
        if (!prstb) begin
            state_q <= IDLE;
            op_q    <= 32'h0;
            rdata_q <= 32'h0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = BUSY;
            BUSY:    if (!en || done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack   = (state_q == IDLE);
        rdata = rdata_q;
    end

    always_comb begin
        op_d        = op_q;
        v_d         = v_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        key_run_d   = key_run_q;
        delta_run_d = delta_run_q;
        rc_run_d    = rc_run_q;
        // Snapshot key/delta/N so register writes never disturb a running block
        if (load) begin
            op_d        = wdata;
            v_d         = wdata;
            sum_d       = sum_init;
            cnt_d       = 3'd0;
            key_run_d   = key_q;
            delta_run_d = delta_q;
            rc_run_d    = rc;
        end else if (step) begin
            v_d   = v_nxt;
            sum_d = sum_nxt;
            cnt_d = cnt_q + 3'd1;
            if (done) rdata_d = v_nxt;
        end
    end

    always_ff @(posedge pclk) begin
        v_q         <= v_d;
        sum_q       <= sum_d;
        key_run_q   <= key_run_d;
        delta_run_q <= delta_run_d;
        rc_run_q    <= rc_run_d;
    end

endmodule

// File: tb/tb_tiny_enc.sv
// Bench for the TEA core: an encrypt instance chained into a decrypt instance,
// with a reference TEA model filling scoreboard queues.
module tb_tiny_enc;

    localparam logic [63:0] KEY   = 64'h816fc52b09e74da3;
    localparam logic [15:0] DELTA = 16'h0123;

    logic        pclk, prstb, clk, req;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] wdata;
    logic [31:0] enc_rdata, dec_rdata;
    logic        enc_ack, dec_ack;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] cur_key;
    logic [15:0] cur_delta;
    logic [31:0] enc_q[$];
    logic [31:0] dec_q[$];

    tiny_enc #(.KEY(KEY), .DELTA(DELTA), .SHL(4), .SHR(5), .DECRYPT(1'b0)) u_enc (
        .pclk(pclk), .prstb(prstb), .clk(clk), .wdata(wdata), .req(req),
        .rdata(enc_rdata), .ack(enc_ack), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata)
    );

    tiny_dec #(.KEY(KEY), .DELTA(DELTA), .SHL(4), .SHR(5)) u_dec (
        .pclk(pclk), .prstb(prstb), .clk(clk), .wdata(enc_rdata), .req(req),
        .rdata(dec_rdata), .ack(dec_ack), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: no finish, vectors=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = addr; pwdata = data;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // Textbook TEA encipher on 16-bit halves
    function automatic logic [31:0] tea_ref(input logic [31:0] p, input logic [63:0] k,
                                            input logic [15:0] d, input int n);
        logic [15:0] y, z, sum;
        y = p[15:0]; z = p[31:16]; sum = 16'h0;
        for (int i = 0; i < n; i++) begin
            sum = sum + d;
            y = y + (((z << 4) + k[15:0]) ^ (z + sum) ^ ((z >> 5) + k[31:16]));
            z = z + (((y << 4) + k[47:32]) ^ (y + sum) ^ ((y >> 5) + k[63:48]));
        end
        return {z, y};
    endfunction

    function automatic logic [31:0] rand_text(input logic [31:0] avoid);
        logic [31:0] t;
        do begin
            for (int b = 0; b < 4; b++) t[b*8 +: 8] = 8'($urandom_range(32'h20, 32'h7e));
        end while (t == avoid);
        return t;
    endfunction

    // Runs right after a wdata change; pops the scoreboard on each ack rise
    task automatic run_chain(input int n, output int enc_rises);
        logic pe, pd;
        bit dec_done;
        logic [31:0] exp;
        pe = enc_ack; pd = dec_ack; dec_done = 0; enc_rises = 0;
        for (int k = 1; k <= 4 * n + 20 && !dec_done; k++) begin
            tick();
            if (!pe && enc_ack) begin
                enc_rises++;
                if (enc_q.size() == 0) check_val("enc_extra_ack", 32'(enc_rises), 32'd1);
                else begin
                    exp = enc_q.pop_front();
                    check_val("enc_rdata", enc_rdata, exp);
                    check_val("enc_latency", 32'(k), 32'(n + 1));
                end
            end
            if (!pd && dec_ack) begin
                dec_done = 1;
                if (dec_q.size() == 0) check_val("dec_extra_ack", 32'd1, 32'd0);
                else begin
                    exp = dec_q.pop_front();
                    check_val("dec_rdata", dec_rdata, exp);
                    check_val("dec_latency", 32'(k), 32'(2 * n + 2));
                end
            end
            pe = enc_ack; pd = dec_ack;
        end
        if (!dec_done) check_val("dec_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] a, b, rd_before, prev;
        int rises, n;

        prstb = 1'b0; clk = 1'b0; req = 1'b0; wdata = 32'h0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
        cur_key = KEY; cur_delta = DELTA;

        // Reset state, then EN=0 blocks starts
        tick(); tick();
        check_val("rst_enc_ack", 32'(enc_ack), 32'd1);
        check_val("rst_enc_rdata", enc_rdata, 32'h0);
        check_val("rst_dec_ack", 32'(dec_ack), 32'd1);
        check_val("rst_dec_rdata", dec_rdata, 32'h0);
        prstb = 1'b1;
        tick();
        wdata = 32'h1234_5678;
        tick(); tick(); tick();
        check_val("en0_ack", 32'(enc_ack), 32'd1);
        check_val("en0_rdata", enc_rdata, 32'h0);
        wdata = 32'h0;

        // Zero key/delta, N=1 known vector
        apb_write(32'h0, 32'h0);
        apb_write(32'h4, 32'h0);
        apb_write(32'h8, 32'h0);
        apb_write(32'hC, 32'h8);
        wdata = 32'h0001_0000;
        tick();
        check_val("n1_ack_low", 32'(enc_ack), 32'd0);
        tick();
        check_val("n1_ack_high", 32'(enc_ack), 32'd1);
        check_val("n1_rdata", enc_rdata, 32'h0102_0011);
        check_val("n1_model", tea_ref(32'h0001_0000, 64'h0, 16'h0, 1), 32'h0102_0011);
        tick(); tick(); tick(); tick();
        req = 1'b1;
        tick(); tick(); tick();
        check_val("req_ack", 32'(enc_ack), 32'd1);
        check_val("req_rdata", enc_rdata, 32'h0102_0011);
        req = 1'b0;

        // Asynchronous reset in the middle of a block
        apb_write(32'hC, 32'hF);
        wdata = 32'h0bad_f00d;
        tick(); tick();
        check_val("pre_rst_busy", 32'(enc_ack), 32'd0);
        prstb = 1'b0;
        #2;
        check_val("mid_rst_ack", 32'(enc_ack), 32'd1);
        check_val("mid_rst_rdata", enc_rdata, 32'h0);
        check_val("mid_rst_dec_rdata", dec_rdata, 32'h0);
        tick();
        prstb = 1'b1;
        cur_key = KEY; cur_delta = DELTA;
        tick(); tick(); tick();
        check_val("post_rst_ctrl0_ack", 32'(enc_ack), 32'd1);
        check_val("post_rst_ctrl0_rdata", enc_rdata, 32'h0);
        wdata = 32'h0;
        tick();

        // Default key/delta, every N, enc -> dec round trip
        for (int rc = 0; rc < 8; rc++) begin
            n = rc + 1;
            apb_write(32'hC, 32'(8 | rc));
            for (int w = 0; w < 33; w++) begin
                a = rand_text(wdata);
                wdata = a;
                enc_q.push_back(tea_ref(a, cur_key, cur_delta, n));
                dec_q.push_back(a);
                run_chain(n, rises);
            end
        end

        // New operand mid-block restarts; only the new operand completes
        apb_write(32'hC, 32'hF);
        a = rand_text(wdata);
        wdata = a;
        tick(); tick(); tick();
        b = rand_text(a);
        wdata = b;
        enc_q.push_back(tea_ref(b, cur_key, cur_delta, 8));
        dec_q.push_back(b);
        run_chain(8, rises);
        check_val("restart_ack_rises", 32'(rises), 32'd1);

        // EN cleared mid-block aborts without touching rdata
        rd_before = enc_rdata;
        prev = wdata;
        wdata = rand_text(prev);
        tick(); tick(); tick();
        check_val("abort_busy", 32'(enc_ack), 32'd0);
        apb_write(32'hC, 32'h5);
        tick();
        check_val("abort_ack", 32'(enc_ack), 32'd1);
        check_val("abort_rdata", enc_rdata, rd_before);
        tick(); tick(); tick();
        check_val("abort_stays_idle", 32'(enc_ack), 32'd1);
        check_val("abort_rdata_hold", enc_rdata, rd_before);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
